// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage and the hazard detection unit:
// fetch FSM state encoding, the NOP instruction word and hazard control codes.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_RUN   = 2'd1,
    FS_STALL = 2'd2
  } fetch_state_t;

  // All-zero word decodes as opcode 5'b00000 (NOP).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Hazard unit control encodings; any other code means "no request".
  localparam logic [1:0] HAZ_STALL = 2'b01;
  localparam logic [1:0] HAZ_FLUSH = 2'b01;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry capture/release register with valid flag.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   capture_i   - load data_i/valid_i
//   release_i   - drop the entry (data kept, valid cleared)
//   clear_i     - discard the entry; highest priority
//   data_i/valid_i - entry to capture
//   data_o/valid_o - stored entry
module fetch_hold_buffer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         capture_i,
  input  logic         release_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  // Entry register: clear beats capture beats release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (capture_i) begin
      data_q  <= data_i;
      valid_q <= valid_i;
    end else if (release_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with the Fetch-Decode pipeline register.
// Owns the PC, drives a 1-cycle-latency synchronous instruction memory and
// keeps the in-flight instruction in a hold buffer while decode is stalled.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   nop_i, flush_i    - hazard unit stall / taken-branch requests (2'b01 active)
//   branch_target_i   - redirect PC on flush
//   imem_addr_o       - memory address (current PC)
//   imem_rdata_i      - memory data for the address issued last cycle
//   ifid_instr_o/pc_o/valid_o - Fetch-Decode register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                PC_WIDTH    = 10,
  parameter int                INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             nop_i,
  input  logic [1:0]             flush_i,
  input  logic [PC_WIDTH-1:0]    branch_target_i,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] ifid_instr_o,
  output logic [PC_WIDTH-1:0]    ifid_pc_o,
  output logic                   ifid_valid_o
);

  localparam logic [INSTR_WIDTH-1:0] NOP_W = INSTR_WIDTH'(NOP_INSTR);

  fetch_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   f1_pc_q, f1_pc_d;
  logic                  f1_valid_q, f1_valid_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]   ifid_pc_q, ifid_pc_d;
  logic                  ifid_valid_q, ifid_valid_d;

  logic                  stall_s, flush_s;
  logic                  hold_cap_s, hold_rel_s, hold_clr_s;
  logic [INSTR_WIDTH-1:0] hold_instr_s;
  logic                  hold_valid_s;

  assign stall_s = (nop_i == HAZ_STALL);
  assign flush_s = (flush_i == HAZ_FLUSH);

  fetch_hold_buffer #(.W(INSTR_WIDTH)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (hold_cap_s),
    .release_i (hold_rel_s),
    .clear_i   (hold_clr_s),
    .data_i    (imem_rdata_i),
    .valid_i   (f1_valid_q),
    .data_o    (hold_instr_s),
    .valid_o   (hold_valid_s)
  );

  // Next-state logic for the PC, the f1 tracking stage and IF/ID.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    f1_pc_d      = f1_pc_q;
    f1_valid_d   = f1_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    hold_cap_s   = 1'b0;
    hold_rel_s   = 1'b0;
    hold_clr_s   = 1'b0;

    if (flush_s) begin
      // Flush beats stall in every state, including boot.
      pc_d         = branch_target_i;
      f1_valid_d   = 1'b0;
      hold_clr_s   = 1'b1;
      ifid_instr_d = NOP_W;
      ifid_valid_d = 1'b0;
      state_d      = FS_RUN;
    end else begin
      case (state_q)
        FS_BOOT: begin
          ifid_instr_d = NOP_W;
          ifid_valid_d = 1'b0;
          if (stall_s) begin
            state_d = FS_BOOT;
          end else begin
            f1_pc_d    = pc_q;
            f1_valid_d = 1'b1;
            pc_d       = pc_q + PC_WIDTH'(1);
            state_d    = FS_RUN;
          end
        end
        FS_RUN: begin
          if (stall_s) begin
            // Memory data would be lost next cycle; park it.
            hold_cap_s = 1'b1;
            state_d    = FS_STALL;
          end else begin
            ifid_instr_d = f1_valid_q ? imem_rdata_i : NOP_W;
            ifid_pc_d    = f1_pc_q;
            ifid_valid_d = f1_valid_q;
            f1_pc_d      = pc_q;
            f1_valid_d   = 1'b1;
            pc_d         = pc_q + PC_WIDTH'(1);
          end
        end
        FS_STALL: begin
          if (stall_s) begin
            state_d = FS_STALL;
          end else begin
            // pc_q was held on the bus during the stall, so it is re-issued
            // now and its data arrives next cycle: no bubble.
            hold_rel_s   = 1'b1;
            ifid_instr_d = hold_valid_s ? hold_instr_s : NOP_W;
            ifid_pc_d    = f1_pc_q;
            ifid_valid_d = hold_valid_s;
            f1_pc_d      = pc_q;
            f1_valid_d   = 1'b1;
            pc_d         = pc_q + PC_WIDTH'(1);
            state_d      = FS_RUN;
          end
        end
        default: begin
          state_d = FS_BOOT;
        end
      endcase
    end
  end

  // State, PC, f1 and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FS_BOOT;
      pc_q         <= RESET_PC;
      f1_pc_q      <= '0;
      f1_valid_q   <= 1'b0;
      ifid_instr_q <= NOP_W;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      f1_pc_q      <= f1_pc_d;
      f1_valid_q   <= f1_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr_o  = pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: main instance (PC_WIDTH=10) and a
// PC_WIDTH=4 instance to observe PC wrap. Memory returns mem[a]=a+100(+bias).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  nop, flush;
  logic [9:0]  tgt;
  logic [9:0]  addr;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [9:0]  pc;
  logic        valid;
  logic [31:0] bias;

  logic [3:0]  addr2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [3:0]  pc2;
  logic        valid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rdata  <= 32'(addr) + 32'd100 + bias;
  always @(posedge clk) rdata2 <= 32'(addr2) + 32'd100;

  fetch_stage #(.PC_WIDTH(10), .INSTR_WIDTH(32), .RESET_PC(10'd0)) dut (
    .clk(clk), .rst_n(rst_n), .nop_i(nop), .flush_i(flush),
    .branch_target_i(tgt), .imem_addr_o(addr), .imem_rdata_i(rdata),
    .ifid_instr_o(instr), .ifid_pc_o(pc), .ifid_valid_o(valid)
  );

  fetch_stage #(.PC_WIDTH(4), .INSTR_WIDTH(32), .RESET_PC(4'd0)) dut2 (
    .clk(clk), .rst_n(rst_n), .nop_i(2'b00), .flush_i(2'b00),
    .branch_target_i(4'd0), .imem_addr_o(addr2), .imem_rdata_i(rdata2),
    .ifid_instr_o(instr2), .ifid_pc_o(pc2), .ifid_valid_o(valid2)
  );

  typedef struct {
    logic [1:0]  nop;
    logic [1:0]  flush;
    logic [9:0]  tgt;
    logic [31:0] bias;
    logic        v;
    logic [9:0]  pc;
    logic [31:0] instr;
    logic [9:0]  addr;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic [1:0] n, input logic [1:0] f,
                              input logic [9:0] t, input logic [31:0] b,
                              input logic v, input logic [9:0] p,
                              input logic [31:0] i, input logic [9:0] a);
    vec_t r;
    r.nop = n; r.flush = f; r.tgt = t; r.bias = b;
    r.v = v; r.pc = p; r.instr = i; r.addr = a;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; nop = 2'b00; flush = 2'b00; tgt = 10'd0; bias = 32'd0;

    // Inputs applied during cycle k; outputs expected in cycle k+1.
    vecs[0]  = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b0, 10'h000, 32'd0,   10'h001);
    vecs[1]  = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h000, 32'd100, 10'h002);
    vecs[2]  = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h001, 32'd101, 10'h003);
    vecs[3]  = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h002, 32'd102, 10'h004);
    vecs[4]  = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h003, 32'd103, 10'h005);
    vecs[5]  = mk(2'b01, 2'b00, 10'h000, 32'd0,  1'b1, 10'h003, 32'd103, 10'h005);
    vecs[6]  = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h004, 32'd104, 10'h006);
    vecs[7]  = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h005, 32'd105, 10'h007);
    vecs[8]  = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h006, 32'd106, 10'h008);
    vecs[9]  = mk(2'b01, 2'b00, 10'h000, 32'd0,  1'b1, 10'h006, 32'd106, 10'h008);
    vecs[10] = mk(2'b01, 2'b00, 10'h000, 32'd50, 1'b1, 10'h006, 32'd106, 10'h008);
    vecs[11] = mk(2'b01, 2'b00, 10'h000, 32'd50, 1'b1, 10'h006, 32'd106, 10'h008);
    vecs[12] = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h007, 32'd107, 10'h009);
    vecs[13] = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h008, 32'd108, 10'h00a);
    vecs[14] = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h009, 32'd109, 10'h00b);
    vecs[15] = mk(2'b00, 2'b01, 10'h040, 32'd0,  1'b0, 10'h000, 32'd0,   10'h040);
    vecs[16] = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b0, 10'h000, 32'd0,   10'h041);
    vecs[17] = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h040, 32'd164, 10'h042);
    vecs[18] = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h041, 32'd165, 10'h043);
    vecs[19] = mk(2'b01, 2'b00, 10'h000, 32'd0,  1'b1, 10'h041, 32'd165, 10'h043);
    vecs[20] = mk(2'b01, 2'b00, 10'h000, 32'd0,  1'b1, 10'h041, 32'd165, 10'h043);
    vecs[21] = mk(2'b01, 2'b01, 10'h080, 32'd0,  1'b0, 10'h000, 32'd0,   10'h080);
    vecs[22] = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b0, 10'h000, 32'd0,   10'h081);
    vecs[23] = mk(2'b00, 2'b00, 10'h000, 32'd0,  1'b1, 10'h080, 32'd228, 10'h082);
    vecs[24] = mk(2'b11, 2'b10, 10'h3ff, 32'd0,  1'b1, 10'h081, 32'd229, 10'h083);
    vecs[25] = mk(2'b10, 2'b11, 10'h3ff, 32'd0,  1'b1, 10'h082, 32'd230, 10'h084);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset_valid", 32'(valid), 32'd0);
    check("reset_instr", instr, 32'd0);
    check("reset_pc",    32'(pc), 32'd0);
    check("reset_addr",  32'(addr), 32'd0);

    for (int k = 0; k < 26; k++) begin
      nop = vecs[k].nop; flush = vecs[k].flush; tgt = vecs[k].tgt; bias = vecs[k].bias;
      @(posedge clk);
      #1;
      check($sformatf("c%0d_valid", k + 1), 32'(valid), 32'(vecs[k].v));
      check($sformatf("c%0d_instr", k + 1), instr, vecs[k].instr);
      check($sformatf("c%0d_addr", k + 1), 32'(addr), 32'(vecs[k].addr));
      if (vecs[k].v)
        check($sformatf("c%0d_pc", k + 1), 32'(pc), 32'(vecs[k].pc));
      if (k + 1 >= 2) begin
        check($sformatf("w%0d_valid", k + 1), 32'(valid2), 32'd1);
        check($sformatf("w%0d_pc", k + 1), 32'(pc2), 32'((k - 1) % 16));
        check($sformatf("w%0d_instr", k + 1), instr2, 32'((k - 1) % 16) + 32'd100);
      end
    end

    // Async reset in the middle of a stall.
    nop = 2'b01; flush = 2'b00; bias = 32'd0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midstall_rst_valid", 32'(valid), 32'd0);
    check("midstall_rst_instr", instr, 32'd0);
    check("midstall_rst_pc",    32'(pc), 32'd0);
    check("midstall_rst_addr",  32'(addr), 32'd0);
    nop = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerun_c1_valid", 32'(valid), 32'd0);
    check("rerun_c1_addr",  32'(addr), 32'd1);
    @(posedge clk);
    #1;
    check("rerun_c2_valid", 32'(valid), 32'd1);
    check("rerun_c2_pc",    32'(pc), 32'd0);
    check("rerun_c2_instr", instr, 32'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
